// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per step over a
// req/ack memory port, presents it for exactly one execute cycle, computes
// the next PC from jump/branch selects and counts retired instructions.
//
// Handshake: imem_req is raised in FETCH and held, with imem_addr stable,
// until a cycle where imem_ack=1; that cycle's imem_rdata is the transfer.
// imem_ack outside FETCH carries no meaning and is ignored. instr_valid is
// a one-cycle strobe with no back-pressure: the consumer must take
// instr/opcode/pc in the cycle it is high, and jump_sel/branch_sel/zero are
// only looked at in that same cycle.
module fetch_unit #(
  parameter int          ADDR_W   = 12,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               jump_sel,
  input  logic               branch_sel,
  input  logic               zero,
  input  logic               halt,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   retired_q;

  logic [ADDR_W-1:0]  pc_seq;
  logic [ADDR_W-1:0]  br_off;
  logic [ADDR_W-1:0]  br_target;
  logic [ADDR_W-1:0]  jmp_target;
  logic [ADDR_W-1:0]  next_pc;

  logic in_fetch;
  logic in_exec;

  assign in_fetch = (state_q == S_FETCH);
  assign in_exec  = (state_q == S_EXEC);

  // Sequencing: halt is only consulted in IDLE and EXEC, so a halt raised
  // during a fetch lets that instruction execute before stopping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = halt ? S_HALTED : S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_EXEC;
      S_EXEC:   state_d = halt ? S_HALTED : S_FETCH;
      S_HALTED: if (!halt) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next-PC selection; all arithmetic wraps at 2^ADDR_W by construction.
  always_comb begin
    pc_seq     = pc_q + ADDR_W'(1);
    br_off     = {{(ADDR_W-8){instr_q[7]}}, instr_q[7:0]};
    br_target  = pc_seq + br_off;
    jmp_target = instr_q[ADDR_W-1:0];
    if (jump_sel)
      next_pc = jmp_target;
    else if (branch_sel && zero)
      next_pc = br_target;
    else
      next_pc = pc_seq;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Instruction register: loaded only by the accepting cycle of a fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      instr_q <= '0;
    else if (in_fetch && imem_ack) instr_q <= imem_rdata;
  end

  // PC and retire counter advance together at the edge closing EXEC; a reset
  // during EXEC therefore discards both updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC_V;
      retired_q <= '0;
    end else if (in_exec) begin
      pc_q      <= next_pc;
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from registered state only.
  assign imem_req    = in_fetch;
  assign imem_addr   = pc_q;
  assign instr_valid = in_exec;
  assign halted      = (state_q == S_HALTED);
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: 4];
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with a wait-state address, a
// control-unit model driven from the expected instruction, and a scoreboard
// of expected execute cycles {pc, instr, retired}.
module tb_fetch_unit;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 8;
  localparam int W       = ADDR_W + INSTR_W + CNT_W;
  localparam logic [ADDR_W-1:0] WAIT_ADDR = 12'h005;
  localparam int WAIT_N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               jump_sel;
  logic               branch_sel;
  logic               zero;
  logic               halt;
  logic               halted;
  logic [CNT_W-1:0]   retired;
  logic [1:0]         dbg_state;

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc),
    .jump_sel(jump_sel), .branch_sel(branch_sel), .zero(zero),
    .halt(halt), .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [INSTR_W-1:0] mem [0:4095];
  logic               zero_mem [0:4095];
  logic [W-1:0]       exp_q[$];

  // memory port muxing: responder model or manual drive
  logic               mem_en    = 1'b1;
  logic               resp_ack  = 1'b0;
  logic [INSTR_W-1:0] resp_rdata = '0;
  logic               man_ack   = 1'b0;
  logic [INSTR_W-1:0] man_rdata = '0;
  assign imem_ack   = mem_en ? resp_ack   : man_ack;
  assign imem_rdata = mem_en ? resp_rdata : man_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] p, input logic [INSTR_W-1:0] i,
                          input logic [CNT_W-1:0] r);
    exp_q.push_back({p, i, r});
  endtask

  // ---------------- memory responder ----------------
  int                wait_left = 0;
  int                req_cycles = 0;
  logic              prev_req = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;

  always @(negedge clk) begin
    if (mem_en) begin
      if (imem_req) begin
        if (!prev_req) begin
          wait_left  = (imem_addr == WAIT_ADDR) ? WAIT_N : 0;
          req_cycles = 0;
          first_addr = imem_addr;
        end
        req_cycles++;
        check("fetch_addr_stable", imem_addr, first_addr);
        if (wait_left > 0) begin
          resp_ack = 1'b0;
          wait_left--;
        end else begin
          resp_ack   = 1'b1;
          resp_rdata = mem[imem_addr];
          if (imem_addr == WAIT_ADDR) check("wait_req_cycles", req_cycles, WAIT_N + 1);
        end
      end else begin
        resp_ack = 1'b0;
      end
      prev_req = imem_req;
    end
  end

  // ---------------- monitor / control-unit model ----------------
  logic [W-1:0]       mon_e;
  logic [INSTR_W-1:0] mon_instr;
  logic [ADDR_W-1:0]  mon_pc;

  always @(negedge clk) begin
    jump_sel   = 1'b0;
    branch_sel = 1'b0;
    zero       = 1'b0;
    if (rst && instr_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_exec: got pc=%0h instr=%0h expected no execute cycle", pc, instr);
      end else begin
        mon_e     = exp_q.pop_front();
        mon_pc    = mon_e[W-1 -: ADDR_W];
        mon_instr = mon_e[CNT_W +: INSTR_W];
        check("exec_pc", pc, mon_pc);
        check("exec_instr", instr, mon_instr);
        check("exec_opcode", opcode, mon_instr[15:12]);
        check("exec_retired", retired, mon_e[CNT_W-1:0]);
        jump_sel   = (mon_instr[15:12] == 4'h2) || (mon_instr[15:12] == 4'h6);
        branch_sel = (mon_instr[15:12] == 4'h4) || (mon_instr[15:12] == 4'h6);
        zero       = zero_mem[mon_pc];
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst  = 1'b0;
    halt = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]      = '0;
      zero_mem[i] = 1'b0;
    end
    mem[12'h005] = 16'h1234;
    mem[12'h006] = 16'h2ABC;
    mem[12'hABD] = 16'h2010;
    mem[12'h010] = 16'h40FE;  zero_mem[12'h010] = 1'b1;
    mem[12'h00F] = 16'h2830;
    mem[12'h830] = 16'h40FE;  zero_mem[12'h830] = 1'b0;
    mem[12'h831] = 16'h6840;  zero_mem[12'h831] = 1'b1;
    mem[12'h840] = 16'h2FFE;

    push_exp(12'h000, 16'h0000, 8'd0);
    push_exp(12'h001, 16'h0000, 8'd1);
    push_exp(12'h002, 16'h0000, 8'd2);
    push_exp(12'h003, 16'h0000, 8'd3);
    push_exp(12'h004, 16'h0000, 8'd4);
    push_exp(12'h005, 16'h1234, 8'd5);   // wait-state fetch
    push_exp(12'h006, 16'h2ABC, 8'd6);   // jump -> ABC
    push_exp(12'hABC, 16'h0000, 8'd7);
    push_exp(12'hABD, 16'h2010, 8'd8);   // jump -> 010
    push_exp(12'h010, 16'h40FE, 8'd9);   // branch taken: 011-2 = 00F
    push_exp(12'h00F, 16'h2830, 8'd10);  // jump -> 830
    push_exp(12'h830, 16'h40FE, 8'd11);  // branch not taken -> 831
    push_exp(12'h831, 16'h6840, 8'd12);  // jump beats branch (872) -> 840
    push_exp(12'h840, 16'h2FFE, 8'd13);  // jump -> FFE
    push_exp(12'hFFE, 16'h0000, 8'd14);
    push_exp(12'hFFF, 16'h0000, 8'd15);  // wraps to 000
    push_exp(12'h000, 16'h2020, 8'd16);  // rewritten word, jump -> 020
    push_exp(12'h020, 16'h0000, 8'd17);  // halt here
    for (int k = 0; k < 240; k++)        // retired wraps 255 -> 0 at pc 10F
      push_exp(12'h021 + 12'(k), 16'h0000, 8'(18 + k));

    // reset values
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_retired", retired, 0);
    repeat (2) @(posedge clk);
    #1 check("rst_held_req", imem_req, 0);

    @(posedge clk);
    #2 rst = 1'b1;

    // first req one cycle after release, then valid every 2nd cycle
    @(posedge clk); #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 12'h000);
    check("first_valid", instr_valid, 0);
    @(posedge clk); #1;
    check("exec0_valid", instr_valid, 1);
    check("exec0_req", imem_req, 0);
    @(posedge clk); #1;
    check("second_req", imem_req, 1);
    check("second_addr", imem_addr, 12'h001);
    check("second_valid", instr_valid, 0);
    check("second_retired", retired, 1);
    @(posedge clk); #1;
    check("exec1_valid", instr_valid, 1);
    mem[12'h000] = 16'h2020;

    // halt during EXEC at pc 020
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk); #1;
      if (instr_valid && pc == 12'h020) found = 1'b1;
    end
    check("halt_exec_seen", found, 1);
    halt = 1'b1;
    @(posedge clk); #1;
    check("halt_halted", halted, 1);
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc, 12'h021);
    check("halt_retired", retired, 18);
    repeat (3) @(posedge clk);
    #1;
    check("halt_hold_halted", halted, 1);
    check("halt_hold_req", imem_req, 0);
    check("halt_hold_pc", pc, 12'h021);
    check("halt_hold_instr", instr, 16'h0000);
    halt = 1'b0;
    @(posedge clk); #1;
    check("resume_halted", halted, 0);
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 12'h021);

    // run until every expected execute cycle has been seen
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("queue_drained", exp_q.size(), 0);

    // async reset in the middle of a fetch
    @(posedge clk); #2;
    check("pre_reset_req", imem_req, 1);
    mem_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("async_req", imem_req, 0);
    check("async_pc", pc, 12'h000);
    check("async_addr", imem_addr, 12'h000);
    check("async_instr", instr, 16'h0000);
    check("async_retired", retired, 0);
    check("async_valid", instr_valid, 0);

    // late ack right after release lands in IDLE and must be ignored
    @(posedge clk); #2;
    rst       = 1'b1;
    man_rdata = 16'hBEEF;
    man_ack   = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    check("late_ack_req", imem_req, 1);
    check("late_ack_addr", imem_addr, 12'h000);
    check("late_ack_instr", instr, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
      check("late_ack_hold_instr", instr, 16'h0000);
      check("late_ack_hold_valid", instr_valid, 0);
      check("late_ack_hold_req", imem_req, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle processor. It owns the program counter, fetches one instruction per step from an instruction memory with a req/ack handshake, and presents the instruction and its 4-bit opcode to the control unit for exactly one execute cycle. During that cycle it computes the next PC from the control unit's jump/branch selects and the ALU zero flag, and it counts retired instructions.

## Interface
- ADDR_W, 12, PC and instruction-memory address width
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
- RESET_PC, 0, PC value loaded on reset
- CNT_W, 16, width of retired-instruction counter

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  fetch address, equals pc while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  INSTR_W  instruction word, sampled when imem_ack=1
- instr  out  INSTR_W  current instruction register
- opcode  out  4  instr[INSTR_W-1 -: 4]
- instr_valid  out  1  high for exactly one cycle per fetched instruction (execute cycle)
- pc  out  ADDR_W  address of the current instruction
- jump_sel  in  1  from control unit; sampled only when instr_valid=1
- branch_sel  in  1  from control unit; sampled only when instr_valid=1
- zero  in  1  ALU zero flag; sampled only when instr_valid=1
- halt  in  1  stop fetching after the current instruction
- halted  out  1  high while in HALTED
- retired  out  CNT_W  number of execute cycles completed

## Operation
- States: IDLE, FETCH, EXEC, HALTED. The FSM enters IDLE on reset.
- IDLE: no request. Next state is HALTED if halt=1, else FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack=1: instr<=imem_rdata, then go to EXEC.
  - With imem_ack=0: stay in FETCH; req and addr are held stable.
- EXEC: instr_valid=1 and imem_req=0. At the closing edge:
  - pc<=next_pc.
  - retired<=retired+1, wrapping modulo 2^CNT_W.
  - Next state is HALTED if halt=1, else FETCH.
- next_pc priority:
  - jump_sel=1: instr[ADDR_W-1:0].
  - Else branch_sel=1 and zero=1: pc+1+sext(instr[7:0]).
  - Otherwise: pc+1.
  - All PC arithmetic is modulo 2^ADDR_W, so it wraps (0xFFF+1=0x000).
- HALTED: halted=1, no request, pc and instr hold. When halt=0, go to FETCH.
- imem_ack outside FETCH is ignored; imem_rdata is not captured.
- jump_sel, branch_sel and zero are don't-care outside EXEC.
- halt is sampled only in IDLE and EXEC. halt during FETCH takes effect at the end of the following EXEC.

## Timing
- Reset (rst=0), immediate and asynchronous:
  - state=IDLE, pc=RESET_PC, instr=0, retired=0.
  - imem_req=0, instr_valid=0, halted=0.
  - opcode=0, imem_addr=RESET_PC.
- The first imem_req is asserted in the first cycle after the first rising edge with rst=1.
- Fetch latency is 1 cycle with a zero-wait memory (ack in the same cycle req rises), otherwise 1+N cycles for N wait cycles. EXEC is always 1 cycle, so peak throughput is 1 instruction per 2 cycles.
- imem_req, imem_addr, instr_valid and halted are decoded from state/registers only, with no combinational path from any input.
- instr, opcode and pc are stable for the whole EXEC cycle. They change only at the edge leaving FETCH (instr) or EXEC (pc).
- Reset asserted mid-FETCH drops imem_req in the same cycle, combinationally via async clear. A late ack after reset release is ignored, because IDLE does not sample it.
- Reset mid-EXEC: the instruction is not retired and the PC update is discarded.

## Test plan
- Reset/idle:
  - Stimulus: rst low, then released; imem_ack tied 1; all words 0x0000.
  - Response: all outputs at reset values while rst=0. The first req appears 1 cycle after release with addr=0x000. instr_valid pulses every 2nd cycle; pc steps 0,1,2; retired increments.
- Wait states:
  - Stimulus: ack delayed 3 cycles on addr 0x005.
  - Response: req and addr=0x005 held 4 cycles, then instr captured and instr_valid high for 1 cycle. No double capture.
- Jump and branch:
  - Jump: instr 0x2ABC with jump_sel=1 → next addr 0xABC.
  - Branch taken: pc=0x010, instr 0x40FE, branch_sel=1, zero=1 → next addr 0x00F.
  - Branch not taken: same but zero=0 → 0x011.
  - Priority: jump_sel and branch_sel both 1 → jump target wins.
- Wrap:
  - Sequential from pc=0xFFF → next fetch 0x000.
  - retired from 0xFFFF → 0x0000 after one more EXEC.
- Halt:
  - halt=1 during EXEC at pc=0x020 → HALTED, halted=1, no req, pc=0x021.
  - Release halt → fetch resumes at 0x021.
- Async reset mid-fetch:
  - rst low between edges while req=1 → req=0 and pc=RESET_PC immediately.
  - ack pulse 1 cycle after release → ignored; instr stays 0.
